// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius sequence player: FSM state encoding,
// one-hot colour constants and a one-hot test.
package genius_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GAP      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_RED    = 4'b0010;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_BLUE   = 4'b1000;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/genius_tick_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a load of
// N-1 on state entry makes the state last exactly N clocks.
module genius_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count register: load wins, otherwise decrement and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/genius_seq_player.sv
// Genius sequence player: plays the first `level` ROM colours, then checks presses.
// Optional press timeout is enabled by defining GENIUS_TIMEOUT_EN.
module genius_seq_player
    import genius_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int ON_CYCLES      = 25,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn_valid,
    input  logic [DATA_W-1:0] btn,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] led,
    output logic [ADDR_W:0]   level,
    output logic              in_ready,
    output logic              win,
    output logic              fail
);

    localparam int MAX_OG = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_OG > TIMEOUT_CYCLES) ? MAX_OG : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(MAX_C) + 1;
    localparam logic [TW-1:0]   ON_LD     = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]   GAP_LD    = TW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0] LEVEL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L     = {{ADDR_W{1'b0}}, 1'b1};
`ifdef GENIUS_TIMEOUT_EN
    localparam logic [TW-1:0]   TO_LD     = TW'(TIMEOUT_CYCLES - 1);
`endif

    state_t              state_r, state_n;
    logic [ADDR_W:0]     level_r, level_n;
    logic [ADDR_W-1:0]   idx_r, idx_n;
    logic [ADDR_W-1:0]   rom_addr_r, rom_addr_n;
    logic [DATA_W-1:0]   led_r, led_n;
    logic                in_ready_r, in_ready_n;
    logic                win_r, win_n;
    logic                fail_r, fail_n;
    logic                tload_s;
    logic [TW-1:0]       tval_s;
    logic                tdone_s;
    logic [ADDR_W:0]     idx_inc_s;
    logic                last_s;
    logic                match_s;

    genius_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tload_s),
        .load_val (tval_s),
        .done     (tdone_s)
    );

    assign idx_inc_s = {1'b0, idx_r} + ONE_L;
    assign last_s    = (idx_inc_s == level_r);
    assign match_s   = is_onehot(32'(btn)) && (btn == rom_data);

    // Next-state, counters and output values for the round sequencer.
    always_comb begin
        state_n    = state_r;
        level_n    = level_r;
        idx_n      = idx_r;
        rom_addr_n = rom_addr_r;
        tload_s    = 1'b0;
        tval_s     = GAP_LD;
        case (state_r)
            S_IDLE, S_WIN, S_FAIL: begin
                if (start) begin
                    state_n    = S_GAP;
                    level_n    = ONE_L;
                    idx_n      = {ADDR_W{1'b0}};
                    rom_addr_n = {ADDR_W{1'b0}};
                    tload_s    = 1'b1;
                    tval_s     = GAP_LD;
                end else begin
                    state_n = state_r;
                end
            end
            S_GAP: begin
                if (tdone_s) begin
                    state_n = S_SHOW_ON;
                    idx_n   = {ADDR_W{1'b0}};
                    tload_s = 1'b1;
                    tval_s  = ON_LD;
                end else begin
                    state_n = state_r;
                end
            end
            S_SHOW_ON: begin
                // Address runs one entry ahead through SHOW_OFF so the next colour
                // is already on rom_data when its registered LED value is captured.
                if (tdone_s) begin
                    state_n    = S_SHOW_OFF;
                    rom_addr_n = last_s ? {ADDR_W{1'b0}} : idx_inc_s[ADDR_W-1:0];
                    tload_s    = 1'b1;
                    tval_s     = GAP_LD;
                end else begin
                    state_n = state_r;
                end
            end
            S_SHOW_OFF: begin
                if (!tdone_s) begin
                    state_n = state_r;
                end else if (!last_s) begin
                    state_n = S_SHOW_ON;
                    idx_n   = idx_inc_s[ADDR_W-1:0];
                    tload_s = 1'b1;
                    tval_s  = ON_LD;
                end else begin
                    state_n = S_WAIT_IN;
                    idx_n   = {ADDR_W{1'b0}};
`ifdef GENIUS_TIMEOUT_EN
                    tload_s = 1'b1;
                    tval_s  = TO_LD;
`endif
                end
            end
            S_WAIT_IN: begin
                if (btn_valid) begin
                    if (!match_s) begin
                        state_n = S_FAIL;
                    end else if (!last_s) begin
                        idx_n      = idx_inc_s[ADDR_W-1:0];
                        rom_addr_n = idx_inc_s[ADDR_W-1:0];
`ifdef GENIUS_TIMEOUT_EN
                        tload_s    = 1'b1;
                        tval_s     = TO_LD;
`endif
                    end else if (level_r == LEVEL_MAX) begin
                        state_n = S_WIN;
                    end else begin
                        state_n    = S_GAP;
                        level_n    = level_r + ONE_L;
                        idx_n      = {ADDR_W{1'b0}};
                        rom_addr_n = {ADDR_W{1'b0}};
                        tload_s    = 1'b1;
                        tval_s     = GAP_LD;
                    end
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (tdone_s) begin
                    state_n = S_FAIL;
                end
`endif
                else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        led_n      = (state_n == S_SHOW_ON) ? rom_data : {DATA_W{1'b0}};
        in_ready_n = (state_n == S_WAIT_IN);
        win_n      = (state_n == S_WIN);
        fail_n     = (state_n == S_FAIL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            level_r    <= {(ADDR_W+1){1'b0}};
            idx_r      <= {ADDR_W{1'b0}};
            rom_addr_r <= {ADDR_W{1'b0}};
            led_r      <= {DATA_W{1'b0}};
            in_ready_r <= 1'b0;
            win_r      <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            level_r    <= level_n;
            idx_r      <= idx_n;
            rom_addr_r <= rom_addr_n;
            led_r      <= led_n;
            in_ready_r <= in_ready_n;
            win_r      <= win_n;
            fail_r     <= fail_n;
        end
    end

    assign rom_addr = rom_addr_r;
    assign led      = led_r;
    assign level    = level_r;
    assign in_ready = in_ready_r;
    assign win      = win_r;
    assign fail     = fail_r;

endmodule
